// File: rtl/test_rand_delay_source_multi_if.sv
// Stream bus for the multi-channel random-delay source: one val/rdy pair
// per channel plus the flattened message bus.
//   val : per-channel valid (source -> sink)
//   rdy : per-channel ready (sink -> source)
//   msg : channel c occupies bits [c*p_msg_nbits +: p_msg_nbits]
`timescale 1ns/1ps
interface test_rand_delay_source_multi_if #(
  parameter int unsigned p_nchannels = 4,
  parameter int unsigned p_msg_nbits = 32
);
  logic [p_nchannels-1:0]             val;
  logic [p_nchannels-1:0]             rdy;
  logic [p_nchannels*p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/test_rand_delay_source_multi.sv
// N-channel test source. Each channel replays a preloaded message list over
// its own val/rdy stream with LFSR-driven inter-message delays bounded by
// max_delay. Channels run independently or in lockstep on message index.
//   clk, reset          : clock, asynchronous active-low reset
//   max_delay           : delay bound in cycles (saturates at 255)
//   lockstep            : mode, captured on start
//   start               : ends the load phase
//   load_*              : message preload port (LOAD phase only)
//   out                 : val/rdy/msg stream bus (master side)
//   done, all_done      : per-channel and global completion flags
`timescale 1ns/1ps
module test_rand_delay_source_multi #(
  parameter int unsigned p_nchannels = 4,
  parameter int unsigned p_msg_nbits = 32,
  parameter int unsigned p_num_msgs  = 1024,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [31:0]                      max_delay,
  input  logic                             lockstep,
  input  logic                             start,
  input  logic                             load_en,
  input  logic [$clog2(p_nchannels)-1:0]   load_chan,
  input  logic [$clog2(p_num_msgs)-1:0]    load_idx,
  input  logic [p_msg_nbits-1:0]           load_msg,
  input  logic                             load_last,
  test_rand_delay_source_multi_if.master   out,
  output logic [p_nchannels-1:0]           done,
  output logic                             all_done
);

  localparam int unsigned CW = $clog2(p_nchannels);
  localparam int unsigned IW = $clog2(p_num_msgs);
  localparam int unsigned NW = IW + 1;
  localparam int unsigned W  = p_msg_nbits;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_DELAY = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One Fibonacci step, taps x^16+x^14+x^13+x^11+1 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [7:0] dmin(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [W-1:0] mem [p_nchannels][p_num_msgs];

  logic [p_nchannels-1:0] fire;
  logic [p_nchannels-1:0] busy;
  logic [p_nchannels-1:0] waiting;
  logic [p_nchannels-1:0] loading;
  logic [p_nchannels-1:0] nonempty;
  logic [15:0]            lfsr0;
  logic [7:0]             md8;
  logic [7:0]             shared_d;
  logic                   ls_q;
  logic                   ls_mode;
  logic                   go;
  logic                   load_wr;
  logic                   ls_release;
  logic                   shared_adv;

  // All channels leave LOAD together on start, so channel 0 speaks for the phase.
  assign go       = start & loading[0];
  assign load_wr  = load_en & loading[0];
  assign ls_mode  = loading[0] ? lockstep : ls_q;
  assign md8      = (|max_delay[31:8]) ? 8'hFF : max_delay[7:0];
  assign shared_d = dmin(lfsr0[7:0], md8);

  // Lockstep group advances once no channel is still offering the current
  // index and at least one channel continues to a next index.
  assign ls_release = ls_q & ~(|busy) & (|waiting);
  assign shared_adv = (go & lockstep & (|nonempty)) | ls_release;

  // Message storage: deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_wr) mem[load_chan][load_idx] <= load_msg;
  end

  // Mode capture and global completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_q     <= 1'b0;
      all_done <= 1'b0;
    end else begin
      if (go) ls_q <= lockstep;
      all_done <= &done;
    end
  end

  for (genvar c = 0; c < p_nchannels; c++) begin : g_ch
    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [7:0]     dcnt_q, dcnt_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           val_q, val_d;
    logic           done_q, done_d;
    logic [W-1:0]   msg_q, msg_d;
    logic           is_last;
    logic           launch;
    logic [7:0]     launch_d;
    logic [IW-1:0]  launch_idx;

    assign is_last     = (NW'(idx_q) + NW'(1)) == cnt_q;
    assign fire[c]     = val_q & out.rdy[c];
    assign busy[c]     = (state_q == S_SEND) & ~fire[c];
    assign waiting[c]  = (state_q == S_WAIT) | (fire[c] & ~is_last);
    assign loading[c]  = (state_q == S_LOAD);
    assign nonempty[c] = (cnt_q != '0);

    assign out.val[c]          = val_q;
    assign out.msg[c*W +: W]   = msg_q;
    assign done[c]             = done_q;

    if (c == 0) begin : g_lfsr0
      assign lfsr0 = lfsr_q;
    end

    // Channel state register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_LOAD;
        idx_q   <= '0;
        cnt_q   <= '0;
        dcnt_q  <= '0;
        lfsr_q  <= p_lfsr_seed ^ 16'(c);
        val_q   <= 1'b0;
        done_q  <= 1'b0;
        msg_q   <= '0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        cnt_q   <= cnt_d;
        dcnt_q  <= dcnt_d;
        lfsr_q  <= lfsr_d;
        val_q   <= val_d;
        done_q  <= done_d;
        msg_q   <= msg_d;
      end
    end

    // Channel next-state and output logic.
    always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      dcnt_d     = dcnt_q;
      lfsr_d     = lfsr_q;
      val_d      = val_q;
      done_d     = done_q;
      msg_d      = msg_q;
      launch     = 1'b0;
      launch_d   = '0;
      launch_idx = idx_q;

      case (state_q)
        S_LOAD: begin
          if (load_wr && load_last && (load_chan == CW'(c)))
            cnt_d = NW'(load_idx) + NW'(1);
          if (go) begin
            if (cnt_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              launch   = 1'b1;
              launch_d = lockstep ? shared_d : dmin(lfsr_q[7:0], md8);
            end
          end
        end
        S_DELAY: begin
          if (dcnt_q == 8'd1) begin
            state_d = S_SEND;
            val_d   = 1'b1;
            msg_d   = mem[c][idx_q];
          end else begin
            dcnt_d = dcnt_q - 8'd1;
          end
        end
        S_SEND: begin
          if (fire[c]) begin
            val_d = 1'b0;
            if (is_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              launch_idx = idx_q + IW'(1);
              idx_d      = launch_idx;
              if (!ls_q) begin
                launch   = 1'b1;
                launch_d = dmin(lfsr_q[7:0], md8);
              end else if (ls_release) begin
                launch   = 1'b1;
                launch_d = shared_d;
              end else begin
                state_d = S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (ls_release) begin
            launch   = 1'b1;
            launch_d = shared_d;
          end
        end
        default: ;
      endcase

      // A zero delay goes straight to SEND; otherwise count down in DELAY.
      if (launch) begin
        if (launch_d == '0) begin
          state_d = S_SEND;
          val_d   = 1'b1;
          msg_d   = mem[c][launch_idx];
        end else begin
          state_d = S_DELAY;
          dcnt_d  = launch_d;
          val_d   = 1'b0;
        end
      end

      // Own LFSR steps per independent draw; channel 0 also serves lockstep draws.
      if (launch && !ls_mode) lfsr_d = lfsr_next(lfsr_q);
      if ((c == 0) && shared_adv) lfsr_d = lfsr_next(lfsr_q);
    end
  end

endmodule

// File: tb/tb_test_rand_delay_source_multi.sv
// Directed bench for test_rand_delay_source_multi: basic replay, bounded
// delays, backpressure hold, lockstep, async reset and a randomized-ready
// scoreboard run.
`timescale 1ns/1ps
module tb_test_rand_delay_source_multi;
  localparam int unsigned NCH  = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned NMSG = 1024;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    max_delay;
  logic           lockstep;
  logic           start;
  logic           load_en;
  logic [1:0]     load_chan;
  logic [9:0]     load_idx;
  logic [W-1:0]   load_msg;
  logic           load_last;
  logic [NCH-1:0] done;
  logic           all_done;
  logic [W-1:0]   m [NCH];

  int checks = 0;
  int errors = 0;

  test_rand_delay_source_multi_if #(.p_nchannels(NCH), .p_msg_nbits(W)) bus ();

  test_rand_delay_source_multi #(
    .p_nchannels(NCH), .p_msg_nbits(W), .p_num_msgs(NMSG), .p_lfsr_seed(16'hACE1)
  ) dut (
    .clk(clk), .reset(rst_n), .max_delay(max_delay), .lockstep(lockstep),
    .start(start), .load_en(load_en), .load_chan(load_chan), .load_idx(load_idx),
    .load_msg(load_msg), .load_last(load_last), .out(bus), .done(done),
    .all_done(all_done)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_m
    assign m[g] = bus.msg[g*W +: W];
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input int c, input int i, input logic [W-1:0] d, input logic last);
    load_en = 1'b1; load_chan = 2'(c); load_idx = 10'(i); load_msg = d; load_last = last;
    tick();
    load_en = 1'b0; load_last = 1'b0;
  endtask

  task automatic load3();
    load(0, 0, 32'h11, 1'b0);
    load(0, 1, 32'h22, 1'b0);
    load(0, 2, 32'h33, 1'b1);
  endtask

  // Leaves the bench 1ns into cycle T+1, T being the start cycle.
  task automatic pulse_start(input logic ls);
    lockstep = ls; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] t6_data(input int c, input int i);
    return 32'hA500_0000 | W'(c * 256 + i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nf;
    int ptr [NCH];
    int gap [NCH];
    logic [NCH-1:0] prev_pend;
    logic [W-1:0]   prev_msg [NCH];
    int rises;
    int settle;
    logic prev_ad;

    max_delay = 32'd0; lockstep = 1'b0; start = 1'b0; load_en = 1'b0;
    load_chan = '0; load_idx = '0; load_msg = '0; load_last = 1'b0;
    bus.rdy = '0; rst_n = 1'b1;

    // Reset state and basic back-to-back replay.
    do_reset();
    @(negedge clk);
    check("rst_val", 64'(bus.val), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_all_done", 64'(all_done), 64'h0);
    tick();
    load3();
    max_delay = 32'd0; bus.rdy = 4'hF;
    pulse_start(1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("t1_val0_c%0d", k), 64'(bus.val[0]), 64'(k <= 3));
      if (k <= 3)
        check($sformatf("t1_msg0_c%0d", k), 64'(m[0]), (k == 1) ? 64'h11 : (k == 2) ? 64'h22 : 64'h33);
      check($sformatf("t1_done_c%0d", k), 64'(done), (k >= 4) ? 64'hF : 64'hE);
      check($sformatf("t1_all_done_c%0d", k), 64'(all_done), 64'(k == 5));
      tick();
    end

    // max_delay=3: every draw from this LFSR sequence saturates at 3.
    do_reset();
    load3();
    max_delay = 32'd3; bus.rdy = 4'hF;
    pulse_start(1'b0);
    nf = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 3) check($sformatf("t2_idle_c%0d", k), 64'(bus.val[0]), 64'h0);
      if (bus.val[0]) begin
        if (nf < 3) begin
          check($sformatf("t2_fire%0d_cycle", nf), 64'(k), 64'(4 * (nf + 1)));
          check($sformatf("t2_fire%0d_msg", nf), 64'(m[0]), 64'(32'h11 * (nf + 1)));
        end
        nf++;
      end
      if (k == 13) check("t2_done0", 64'(done[0]), 64'h1);
      tick();
    end
    check("t2_nfires", 64'(nf), 64'd3);

    // Backpressure: rdy[0] low for 5 cycles.
    do_reset();
    load3();
    max_delay = 32'd0; bus.rdy = 4'b1110;
    pulse_start(1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) bus.rdy = 4'hF;
      @(negedge clk);
      if (k <= 6) begin
        check($sformatf("t3_hold_val_c%0d", k), 64'(bus.val[0]), 64'h1);
        check($sformatf("t3_hold_msg_c%0d", k), 64'(m[0]), 64'h11);
      end else if (k <= 8) begin
        check($sformatf("t3_val_c%0d", k), 64'(bus.val[0]), 64'h1);
        check($sformatf("t3_msg_c%0d", k), 64'(m[0]), (k == 7) ? 64'h22 : 64'h33);
      end else begin
        check("t3_done0", 64'(done[0]), 64'h1);
        check("t3_val_after_done", 64'(bus.val[0]), 64'h0);
      end
      tick();
    end

    // Lockstep with channel 1 held off for 4 cycles.
    do_reset();
    load(0, 0, 32'hA0, 1'b0);
    load(0, 1, 32'hA1, 1'b1);
    load(1, 0, 32'hB0, 1'b0);
    load(1, 1, 32'hB1, 1'b1);
    max_delay = 32'd0; bus.rdy = 4'b0001;
    pulse_start(1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) bus.rdy = 4'b0011;
      @(negedge clk);
      if (k == 1) begin
        check("t4_val_c1", 64'(bus.val), 64'h3);
        check("t4_msg0_c1", 64'(m[0]), 64'hA0);
        check("t4_msg1_c1", 64'(m[1]), 64'hB0);
      end else if (k <= 5) begin
        check($sformatf("t4_wait_val_c%0d", k), 64'(bus.val), 64'h2);
        check($sformatf("t4_wait_msg1_c%0d", k), 64'(m[1]), 64'hB0);
      end else if (k == 6) begin
        check("t4_val_c6", 64'(bus.val), 64'h3);
        check("t4_msg0_c6", 64'(m[0]), 64'hA1);
        check("t4_msg1_c6", 64'(m[1]), 64'hB1);
        check("t4_done_c6", 64'(done), 64'hC);
      end else if (k == 7) begin
        check("t4_val_c7", 64'(bus.val), 64'h0);
        check("t4_done_c7", 64'(done), 64'hF);
        check("t4_all_done_c7", 64'(all_done), 64'h0);
      end else begin
        check("t4_all_done_c8", 64'(all_done), 64'h1);
      end
      tick();
    end

    // Async reset mid-SEND on channel 2, then restart without reloading.
    do_reset();
    load(2, 0, 32'hC0, 1'b0);
    load(2, 1, 32'hC1, 1'b1);
    max_delay = 32'd0; bus.rdy = 4'b1011;
    pulse_start(1'b0);
    @(negedge clk);
    check("t5_val_pre", 64'(bus.val), 64'h4);
    check("t5_msg2_pre", 64'(m[2]), 64'hC0);
    check("t5_done_pre", 64'(done), 64'hB);
    #2 rst_n = 1'b0;
    #1;
    check("t5_val_async", 64'(bus.val), 64'h0);
    check("t5_done_async", 64'(done), 64'h0);
    check("t5_all_done_async", 64'(all_done), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start(1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t5_done_restart", 64'(done), 64'hF);
        check("t5_val_restart", 64'(bus.val), 64'h0);
      end else begin
        check("t5_all_done_restart", 64'(all_done), 64'h1);
      end
      tick();
    end

    // Independent run, random ready, scoreboard per channel.
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 8; i++)
        load(c, i, t6_data(c, i), i == 7);
    max_delay = 32'd7;
    for (int c = 0; c < NCH; c++) begin
      ptr[c] = 0; gap[c] = 0; prev_msg[c] = '0;
    end
    prev_pend = '0; rises = 0; settle = -1; prev_ad = 1'b0;
    bus.rdy = 4'($urandom_range(0, 15));
    pulse_start(1'b0);
    for (int k = 1; k <= 2000; k++) begin
      bus.rdy = 4'($urandom_range(0, 15));
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (prev_pend[c]) begin
          check($sformatf("t6_hold_val_ch%0d", c), 64'(bus.val[c]), 64'h1);
          check($sformatf("t6_hold_msg_ch%0d", c), 64'(m[c]), 64'(prev_msg[c]));
        end
        if (bus.val[c]) begin
          if (gap[c] >= 0) begin
            check($sformatf("t6_gap_ch%0d", c), 64'(gap[c] <= 7), 64'h1);
            gap[c] = -1;
          end
          if (bus.rdy[c]) begin
            if (ptr[c] < 8)
              check($sformatf("t6_msg_ch%0d_%0d", c, ptr[c]), 64'(m[c]), 64'(t6_data(c, ptr[c])));
            else
              check($sformatf("t6_overrun_ch%0d", c), 64'(ptr[c]), 64'd7);
            ptr[c]++;
            gap[c] = 0;
          end
        end else if (gap[c] >= 0) begin
          gap[c]++;
        end
        prev_pend[c] = bus.val[c] & ~bus.rdy[c];
        prev_msg[c]  = m[c];
      end
      if (all_done && !prev_ad) rises++;
      prev_ad = all_done;
      if (all_done && settle < 0) settle = k;
      tick();
      if (settle >= 0 && k >= settle + 10) break;
    end
    check("t6_all_done_seen", 64'(settle >= 0), 64'h1);
    check("t6_all_done_rises", 64'(rises), 64'd1);
    for (int c = 0; c < NCH; c++)
      check($sformatf("t6_count_ch%0d", c), 64'(ptr[c]), 64'd8);
    check("t6_done", 64'(done), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
